// File: rtl/cw305_bridge_pkg.sv
// Shared definitions for the CW305 USB-to-instruction-register bridge.
package cw305_bridge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_FILL     = 2'd1,
      ST_LOAD     = 2'd2,
      ST_WAIT_ACK = 2'd3
   } state_t;

   // usb_addr decode; 0-3 are byte lanes, 7 is reserved and ignored
   localparam logic [2:0] ADDR_COMMIT  = 3'd4;
   localparam logic [2:0] ADDR_ABORT   = 3'd5;
   localparam logic [2:0] ADDR_CLR_ERR = 3'd6;

   // status_o bit positions
   localparam int STAT_BUSY           = 0;
   localparam int STAT_MASK_LO        = 1;
   localparam int STAT_ERR_INCOMPLETE = 5;
   localparam int STAT_ERR_BUSY       = 6;
   localparam int STAT_ERR_TIMEOUT    = 7;

   function automatic logic is_lane(input logic [2:0] addr);
      return (addr[2] == 1'b0);
   endfunction

endpackage

// File: rtl/ack_timer.sv
// Down-counting ack timeout. Loaded with ACK_TIMEOUT when the LOAD cycle
// begins; expired flags the ACK_TIMEOUT-th cycle counted from LOAD inclusive.
module ack_timer #(
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic clear,
   output logic expired
);

   localparam int W = $clog2(ACK_TIMEOUT + 1);

   logic [W-1:0] count;

   // load on start, run down to zero, clear on early exit
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (start) begin
         count <= W'(ACK_TIMEOUT);
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   // terminal count of 1 is the last cycle of the window, so the FSM can
   // leave on that same edge
   assign expired = (count == W'(1));

endmodule

// File: rtl/instr_loader.sv
// Assembles a 32-bit instruction from USB byte writes, pulses LOAD and
// waits for the downstream ack with a timeout.
//
//  state       | meaning
//  ST_IDLE     | no lanes written since last transfer/abort
//  ST_FILL     | at least one byte lane written, waiting for COMMIT
//  ST_LOAD     | load_o high for this single cycle
//  ST_WAIT_ACK | waiting for instr_ack_i or timeout
module instr_loader
   import cw305_bridge_pkg::*;
#(
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        usb_wr_en,
   input  logic [2:0]  usb_addr,
   input  logic [7:0]  usb_wdata,
   input  logic        instr_ack_i,
   output logic        load_o,
   output logic [31:0] instr_o,
   output logic [7:0]  status_o,
   output logic [15:0] instr_count_o
);

   state_t      state;
   logic [31:0] word;
   logic [3:0]  mask;
   logic        err_inc;
   logic        err_busy;
   logic        err_to;
   logic [15:0] count_q;
   logic        load_q;

   logic lane_wr, commit_wr, abort_wr, clr_wr;
   logic in_flight;
   logic timer_start, timer_clear, timer_expired;
   logic set_inc, set_busy, set_to;

   // write decode and error/timer qualifiers
   always_comb begin
      lane_wr     = usb_wr_en && is_lane(usb_addr);
      commit_wr   = usb_wr_en && (usb_addr == ADDR_COMMIT);
      abort_wr    = usb_wr_en && (usb_addr == ADDR_ABORT);
      clr_wr      = usb_wr_en && (usb_addr == ADDR_CLR_ERR);
      in_flight   = (state == ST_LOAD) || (state == ST_WAIT_ACK);
      timer_start = !in_flight && commit_wr && (mask == 4'hF);
      timer_clear = in_flight && (instr_ack_i || abort_wr || timer_expired);
      set_inc     = !in_flight && commit_wr && (mask != 4'hF);
      set_busy    = in_flight && (lane_wr || commit_wr);
      // ack and abort both take precedence over the timeout
      set_to      = in_flight && !instr_ack_i && !abort_wr && timer_expired;
   end

   ack_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_ack_timer (
      .clk     (clk),
      .rst     (rst),
      .start   (timer_start),
      .clear   (timer_clear),
      .expired (timer_expired)
   );

   // main sequencing FSM with registered outputs and sticky errors
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         word     <= '0;
         mask     <= '0;
         err_inc  <= 1'b0;
         err_busy <= 1'b0;
         err_to   <= 1'b0;
         count_q  <= '0;
         load_q   <= 1'b0;
      end else begin
         load_q   <= 1'b0;
         err_inc  <= (err_inc  && !clr_wr) || set_inc;
         err_busy <= (err_busy && !clr_wr) || set_busy;
         err_to   <= (err_to   && !clr_wr) || set_to;
         case (state)
            ST_IDLE, ST_FILL: begin
               if (lane_wr) begin
                  word[{usb_addr[1:0], 3'b000} +: 8] <= usb_wdata;
                  mask[usb_addr[1:0]]                <= 1'b1;
                  state                              <= ST_FILL;
               end else if (commit_wr && (mask == 4'hF)) begin
                  state  <= ST_LOAD;
                  load_q <= 1'b1;
               end else if (abort_wr) begin
                  mask  <= '0;
                  state <= ST_IDLE;
               end
            end
            ST_LOAD, ST_WAIT_ACK: begin
               if (instr_ack_i) begin
                  state   <= ST_IDLE;
                  mask    <= '0;
                  count_q <= count_q + 16'd1;
               end else if (abort_wr || timer_expired) begin
                  state <= ST_IDLE;
                  mask  <= '0;
               end else begin
                  state <= ST_WAIT_ACK;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // status word assembled straight from flops
   always_comb begin
      status_o                           = '0;
      status_o[STAT_BUSY]                = in_flight;
      status_o[STAT_MASK_LO +: 4]        = mask;
      status_o[STAT_ERR_INCOMPLETE]      = err_inc;
      status_o[STAT_ERR_BUSY]            = err_busy;
      status_o[STAT_ERR_TIMEOUT]         = err_to;
   end

   assign load_o        = load_q;
   assign instr_o       = word;
   assign instr_count_o = count_q;

endmodule
